coeff_token_flc_decoder: RTL and testbench



---
 rtl/cavlc_pkg.sv | 29 ++
 rtl/coeff_token_flc_decoder_if.sv | 33 +++
 rtl/coeff_token_flc_lut.sv | 28 ++
 rtl/coeff_token_flc_decoder.sv | 122 ++++++++++++
 tb/tb_coeff_token_flc_decoder.sv | 278 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/cavlc_pkg.sv
// Shared CAVLC types and constants for the coeff_token FLC path (nC >= 8 table).
// The coeff_token struct is common to the encoder-side and decoder-side lookups.
package cavlc_pkg;

  localparam int          CT_FLC_LEN = 6;
  localparam logic [5:0]  CT_FLC_TC0 = 6'b000011;
  localparam int          TC_W       = 5;
  localparam int          T1_W       = 2;
  localparam logic [2:0]  CT_CNT_LAST = 3'(CT_FLC_LEN - 1);

  typedef struct packed {
    logic [TC_W-1:0] total_coeff;
    logic [T1_W-1:0] trailing_ones;
    logic            err;
  } coeff_token_t;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_HOLD    = 1'b1
  } ct_state_t;

  // Observable decoder internals: FSM state, bit counter and shift register.
  typedef struct packed {
    ct_state_t  state;
    logic [2:0] cnt;
    logic [5:0] sr;
  } ct_dec_dbg_t;

endpackage

// File: rtl/coeff_token_flc_decoder_if.sv
// Bitstream-in / token-out bus of the coeff_token FLC decoder.
// Handshake: a transfer happens on a rising edge where valid and ready are both 1;
// valid must not depend on ready, and a source holds its data until that edge.
interface coeff_token_flc_decoder_if
  import cavlc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
);
  logic                 bit_in;
  logic                 bit_valid;
  logic                 bit_ready;
  logic                 out_valid;
  logic                 out_ready;
  logic [TC_W-1:0]      total_coeff;
  logic [T1_W-1:0]      trailing_ones;
  logic                 code_err;
  logic                 err_sticky;
  logic [CNT_WIDTH-1:0] token_cnt;

  // master: bitstream source plus token sink; slave: the decoder
  modport master (
    output bit_in, bit_valid, out_ready,
    input  bit_ready, out_valid, total_coeff, trailing_ones,
           code_err, err_sticky, token_cnt
  );

  modport slave (
    input  bit_in, bit_valid, out_ready,
    output bit_ready, out_valid, total_coeff, trailing_ones,
           code_err, err_sticky, token_cnt
  );

endinterface

// File: rtl/coeff_token_flc_lut.sv
// Combinational map from a 6-bit coeff_token FLC codeword to (TotalCoeff, TrailingOnes).
// Codewords whose TrailingOnes would exceed TotalCoeff are reported as errors with zero fields.
module coeff_token_flc_lut
  import cavlc_pkg::*;
(
  input  logic [5:0]   code,
  output coeff_token_t token
);

  logic [TC_W-1:0] tc;
  logic [T1_W-1:0] t1;

  assign tc = {1'b0, code[5:2]} + 5'd1;
  assign t1 = code[1:0];

  always_comb begin
    token = '0;
    if (code == CT_FLC_TC0) begin
      token = '0;
    end else if ({3'b000, t1} > tc) begin
      token.err = 1'b1;
    end else begin
      token.total_coeff   = tc;
      token.trailing_ones = t1;
    end
  end

endmodule

// File: rtl/coeff_token_flc_decoder.sv
// Bit-serial H.264 CAVLC coeff_token decoder for the 6-bit fixed-length table.
// Collects codewords MSB-first and holds each decoded token until downstream takes it.
module coeff_token_flc_decoder
  import cavlc_pkg::*;
#(
  parameter int CNT_WIDTH = 16
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  coeff_token_flc_decoder_if.slave bus,
  output ct_dec_dbg_t              dbg
);

  ct_state_t            state_q, state_d;
  logic [2:0]           cnt_q, cnt_d;
  logic [5:0]           sr_q, sr_d;
  coeff_token_t         tok_q, tok_d;
  logic                 out_valid_q, out_valid_d;
  logic                 sticky_q, sticky_d;
  logic [CNT_WIDTH-1:0] tcnt_q, tcnt_d;

  logic                 bit_ready;
  logic                 accept;
  logic [5:0]           code_next;
  coeff_token_t         dec;

  // In HOLD a bit may only enter in the cycle the pending token leaves, so no bubble is lost.
  assign bit_ready = !flush && ((state_q == ST_COLLECT) || bus.out_ready);
  assign accept    = bit_ready && bus.bit_valid;
  assign code_next = {sr_q[4:0], bus.bit_in};

  coeff_token_flc_lut u_lut (
    .code  (code_next),
    .token (dec)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_COLLECT;
      cnt_q       <= '0;
      sr_q        <= '0;
      tok_q       <= '0;
      out_valid_q <= 1'b0;
      sticky_q    <= 1'b0;
      tcnt_q      <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      tok_q       <= tok_d;
      out_valid_q <= out_valid_d;
      sticky_q    <= sticky_d;
      tcnt_q      <= tcnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    tok_d       = tok_q;
    out_valid_d = out_valid_q;
    sticky_d    = sticky_q;
    tcnt_d      = tcnt_q;

    if (flush) begin
      state_d     = ST_COLLECT;
      cnt_d       = '0;
      sr_d        = '0;
      tok_d       = '0;
      out_valid_d = 1'b0;
      sticky_d    = 1'b0;
      tcnt_d      = '0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (accept) begin
            sr_d = code_next;
            if (cnt_q == CT_CNT_LAST) begin
              cnt_d       = '0;
              tok_d       = dec;
              sticky_d    = sticky_q | dec.err;
              out_valid_d = 1'b1;
              state_d     = ST_HOLD;
            end else begin
              cnt_d = cnt_q + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (bus.out_ready) begin
            tcnt_d      = tcnt_q + CNT_WIDTH'(1);
            out_valid_d = 1'b0;
            state_d     = ST_COLLECT;
            // A bit taken alongside the token handshake starts the next codeword.
            if (accept) begin
              sr_d  = code_next;
              cnt_d = 3'd1;
            end else begin
              cnt_d = '0;
            end
          end
        end
        default: state_d = ST_COLLECT;
      endcase
    end
  end

  assign bus.bit_ready     = bit_ready;
  assign bus.out_valid     = out_valid_q;
  assign bus.total_coeff   = tok_q.total_coeff;
  assign bus.trailing_ones = tok_q.trailing_ones;
  assign bus.code_err      = tok_q.err;
  assign bus.err_sticky    = sticky_q;
  assign bus.token_cnt     = tcnt_q;

  assign dbg.state = state_q;
  assign dbg.cnt   = cnt_q;
  assign dbg.sr    = sr_q;

endmodule

// File: tb/tb_coeff_token_flc_decoder.sv
// Directed bench for coeff_token_flc_decoder: handshake timing, stalls, flush, async reset,
// full codeword sweep and token counter wrap on a 4-bit-counter instance.
module tb_coeff_token_flc_decoder;
  import cavlc_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  coeff_token_flc_decoder_if #(.CNT_WIDTH(16)) bus ();
  coeff_token_flc_decoder_if #(.CNT_WIDTH(4))  bus4 ();
  ct_dec_dbg_t dbg, dbg4;

  coeff_token_flc_decoder #(.CNT_WIDTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus),
    .dbg   (dbg)
  );

  coeff_token_flc_decoder #(.CNT_WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus4),
    .dbg   (dbg4)
  );

  assign bus4.bit_in    = bus.bit_in;
  assign bus4.bit_valid = bus.bit_valid;
  assign bus4.out_ready = bus.out_ready;

  logic [5:0]   lut_code;
  coeff_token_t lut_tok;

  coeff_token_flc_lut u_ref (
    .code  (lut_code),
    .token (lut_tok)
  );

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];   // {err, total_coeff[4:0], trailing_ones[1:0]}
  int n_checks = 0;
  int n_err    = 0;
  int stalls   = 0;

  function automatic logic [7:0] ref_tok(input logic [5:0] c);
    logic [4:0] tc;
    if (c == 6'b000011) return 8'h00;
    if (c == 6'b000010 || c == 6'b000111) return 8'h80;
    tc = 5'(c[5:2]) + 5'd1;
    return {1'b0, tc, c[1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_tok(input string tag);
    logic [7:0] e;
    e = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
    check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    check({tag, "_tok"}, 32'({bus.code_err, bus.total_coeff, bus.trailing_ones}), 32'(e));
  endtask

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b);
    int w;
    @(negedge clk);
    bus.bit_valid = 1'b1;
    bus.bit_in    = b;
    w = 0;
    #1;
    while (!bus.bit_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
      stalls++;
    end
    if (!bus.bit_ready) check("bit_ready_timeout", 32'(bus.bit_ready), 32'd1);
    @(posedge clk);
    #1;
    bus.bit_valid = 1'b0;
  endtask

  task automatic send_code(input logic [5:0] c);
    for (int i = 5; i >= 0; i--) send_bit(c[i]);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int t_first;
    int ill;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b1;
    lut_code      = '0;

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_bit_ready", 32'(bus.bit_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_tc", 32'(bus.total_coeff), 32'd0);
    check("rst_t1", 32'(bus.trailing_ones), 32'd0);
    check("rst_code_err", 32'(bus.code_err), 32'd0);
    check("rst_sticky", 32'(bus.err_sticky), 32'd0);
    check("rst_token_cnt", 32'(bus.token_cnt), 32'd0);
    check("rst_state", 32'(dbg.state), 32'(ST_COLLECT));
    @(negedge clk);
    rst_n = 1'b1;

    // 000011 -> TC=0,T1=0, out_valid for one cycle
    exp_q.push_back(8'h00);
    send_code(6'b000011);
    check_tok("tc0");
    check("tc0_cnt_before", 32'(bus.token_cnt), 32'd0);
    @(posedge clk); #1;
    check("tc0_valid_drop", 32'(bus.out_valid), 32'd0);
    check("tc0_cnt_after", 32'(bus.token_cnt), 32'd1);

    // back-to-back 111111 then 001011
    exp_q.push_back({1'b0, 5'd16, 2'd3});
    send_code(6'b111111);
    check_tok("b2b_a");
    t_first = cyc;
    stalls  = 0;
    exp_q.push_back({1'b0, 5'd3, 2'd3});
    send_code(6'b001011);
    check_tok("b2b_b");
    check("b2b_spacing", 32'(cyc - t_first), 32'd6);
    check("b2b_stalls", 32'(stalls), 32'd0);
    check("b2b_cnt", 32'(bus.token_cnt), 32'd2);
    @(posedge clk); #1;
    check("b2b_cnt_after", 32'(bus.token_cnt), 32'd3);

    // illegal 000010 then legal 000001, sticky error persists
    exp_q.push_back(8'h80);
    send_code(6'b000010);
    check_tok("ill");
    check("ill_sticky", 32'(bus.err_sticky), 32'd1);
    exp_q.push_back({1'b0, 5'd1, 2'd1});
    send_code(6'b000001);
    check_tok("after_ill");
    check("after_ill_sticky", 32'(bus.err_sticky), 32'd1);
    check("after_ill_cnt", 32'(bus.token_cnt), 32'd4);
    @(posedge clk); #1;

    // stall in HOLD with a bit pending, then release
    bus.out_ready = 1'b0;
    exp_q.push_back({1'b0, 5'd5, 2'd0});
    send_code(6'b010000);
    check_tok("stall");
    @(negedge clk);
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("stall_bit_ready", 32'(bus.bit_ready), 32'd0);
      @(posedge clk); #1;
      check("stall_hold", 32'({bus.out_valid, bus.code_err, bus.total_coeff, bus.trailing_ones}),
            32'({1'b1, 1'b0, 5'd5, 2'd0}));
      check("stall_cnt", 32'(bus.token_cnt), 32'd5);
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    #1;
    check("release_bit_ready", 32'(bus.bit_ready), 32'd1);
    @(posedge clk); #1;
    bus.bit_valid = 1'b0;
    check("release_cnt", 32'(bus.token_cnt), 32'd6);
    check("release_valid", 32'(bus.out_valid), 32'd0);
    check("release_bitcnt", 32'(dbg.cnt), 32'd1);
    exp_q.push_back({1'b0, 5'd9, 2'd0});
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    check_tok("release_next");
    @(posedge clk); #1;
    check("release_next_cnt", 32'(bus.token_cnt), 32'd7);

    // flush mid-codeword
    send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
    @(negedge clk);
    flush = 1'b1;
    bus.bit_valid = 1'b1;
    bus.bit_in    = 1'b1;
    #1;
    check("flush_bit_ready", 32'(bus.bit_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    bus.bit_valid = 1'b0;
    check("flush_cnt", 32'(bus.token_cnt), 32'd0);
    check("flush_sticky", 32'(bus.err_sticky), 32'd0);
    check("flush_bitcnt", 32'(dbg.cnt), 32'd0);
    exp_q.push_back({1'b0, 5'd2, 2'd0});
    send_code(6'b000100);
    check_tok("post_flush");
    check("post_flush_cnt", 32'(bus.token_cnt), 32'd0);
    check("post_flush_sticky", 32'(bus.err_sticky), 32'd0);
    @(posedge clk); #1;
    check("post_flush_cnt2", 32'(bus.token_cnt), 32'd1);

    // flush while HOLD with out_ready=1: token discarded, not counted
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h00);
    send_code(6'b000011);
    check_tok("hold_flush");
    @(negedge clk);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("hold_flush_valid", 32'(bus.out_valid), 32'd0);
    check("hold_flush_cnt", 32'(bus.token_cnt), 32'd0);

    // async reset mid-HOLD
    exp_q.push_back(8'h00);
    send_code(6'b000011);
    check_tok("pre_rst_a");
    @(posedge clk); #1;
    check("pre_rst_cnt", 32'(bus.token_cnt), 32'd1);
    bus.out_ready = 1'b0;
    exp_q.push_back(8'h80);
    send_code(6'b000010);
    check_tok("pre_rst_b");
    check("pre_rst_sticky", 32'(bus.err_sticky), 32'd1);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(bus.out_valid), 32'd0);
    check("arst_cnt", 32'(bus.token_cnt), 32'd0);
    check("arst_sticky", 32'(bus.err_sticky), 32'd0);
    check("arst_bit_ready", 32'(bus.bit_ready), 32'd1);
    check("arst_code_err", 32'(bus.code_err), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    bus.out_ready = 1'b1;

    // full 64-codeword sweep, plus wrap of the 4-bit counter instance
    ill = 0;
    for (int k = 0; k < 64; k++) begin
      lut_code = 6'(k);
      exp_q.push_back(ref_tok(6'(k)));
      send_code(6'(k));
      check_tok("sweep");
      check("sweep_lut", 32'({lut_tok.err, lut_tok.total_coeff, lut_tok.trailing_ones}),
            32'(ref_tok(6'(k))));
      check("sweep_cnt", 32'(bus.token_cnt), 32'(k));
      if (bus.code_err) ill++;
      if (k == 15) check("wrap_all_ones", 32'(bus4.token_cnt), 32'd15);
      if (k == 16) check("wrap_zero", 32'(bus4.token_cnt), 32'd0);
    end
    check("sweep_illegal_count", 32'(ill), 32'd2);
    @(posedge clk); #1;
    check("sweep_final_cnt", 32'(bus.token_cnt), 32'd64);
    check("sweep_final_cnt4", 32'(bus4.token_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
